// File: rtl/pipo_write_arbiter.sv
// Round-robin arbiter that grants one requester at a time and commits its data into a shared PIPO register.
// Optional macro PIPO_ARB_LOCK_EN adds a per-requester lock input for back-to-back commits while granted.
module pipo_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    wdata,
`ifdef PIPO_ARB_LOCK_EN
  input  logic [NREQ-1:0]          lock,
`endif
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     valid
);

  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      gidx_q;
  logic [NREQ-1:0]    gnt_q;
  logic [NREQ-1:0]    ack_q;
  logic [WIDTH-1:0]   data_q;
  logic [IW-1:0]      owner_q;
  logic               valid_q;

  logic [IW-1:0]      sel_s;
  logic               found_s;
  int                 idx_s;

  // Round-robin search: first set request bit starting just after the last committed owner.
  always_comb begin
    sel_s   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_s = (int'(ptr_q) + i) % NREQ;
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        sel_s   = IW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Arbitration FSM together with the shared register and its status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      gidx_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (found_s) begin
            gidx_q  <= sel_s;
            gnt_q   <= ONE << sel_s;
            state_q <= GRANT;
          end else begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (req[gidx_q]) begin
            data_q  <= wdata[int'(gidx_q)*WIDTH +: WIDTH];
            ack_q   <= ONE << gidx_q;
            owner_q <= gidx_q;
            valid_q <= 1'b1;
            ptr_q   <= gidx_q;
`ifdef PIPO_ARB_LOCK_EN
            // A locked grant keeps ownership so the next cycle can commit again.
            if (lock[gidx_q]) begin
              state_q <= GRANT;
            end else begin
              gnt_q   <= '0;
              state_q <= IDLE;
            end
`else
            gnt_q   <= '0;
            state_q <= IDLE;
`endif
          end else begin
            ack_q   <= '0;
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign q     = data_q;
  assign owner = owner_q;
  assign valid = valid_q;

endmodule

// File: doc/pipo_write_arbiter.md
Name: pipo_write_arbiter

Overview:
Round-robin arbiter that shares one parallel-in/parallel-out register between NREQ requesters. Each requester raises a request with its parallel data. The block grants one requester at a time, commits that requester's data into the shared register, and acknowledges it. Sits in front of the shared PIPO storage, which is embedded here, and replaces ad-hoc direct drive of the register's write enable.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, register/data width in bits

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req  input  NREQ  request per requester; bit i = requester i
wdata  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, registered
ack  output  NREQ  one-hot, one-cycle pulse: write committed for requester i
q  output  WIDTH  shared register contents
owner  output  $clog2(NREQ)  index of last requester whose write committed
valid  output  1  high once any write has committed since reset

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset, immediate: q=0, gnt=0, ack=0, owner=0, valid=0, state=IDLE. Round-robin pointer ptr=NREQ-1, so requester 0 has first priority.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE; gnt=0.
  - Otherwise select the first set req bit, searching from (ptr+1) mod NREQ upward with wrap-around.
  - Register gnt=onehot(sel) and go to GRANT.
- GRANT, with granted index g:
  - If req[g]==1 at the edge: q<=wdata[g], ack[g]=1 for one cycle, owner<=g, valid<=1, ptr<=g, gnt<=0, go to IDLE.
  - If req[g]==0 at the edge (abandon): no write, no ack, ptr unchanged, gnt<=0, go to IDLE.
- Latency: req sampled at edge k gives gnt high after k; q updated and ack high after k+1. Throughput is one write per 2 cycles.
- Requester rules:
  - Hold req and wdata stable from raising req until ack.
  - Deassert req in the ack cycle if done.
  - If req is still high after ack, the requester re-enters arbitration at lowest priority.
- Requests arriving during GRANT are not sampled until the return to IDLE.
- ack and gnt are never high in the same cycle for the same index (without the lock feature). At most one ack bit is high in any cycle.
- q holds its value in every cycle without a commit.
- Reset asserted during GRANT aborts the write: q is cleared and no ack is issued.

Optional Feature:
Macro PIPO_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (NREQ bits).
  - In GRANT, if the commit condition holds and lock[g]==1: commit (q<=wdata[g], ack[g] pulse, owner, valid, ptr<=g) but stay in GRANT with gnt held. This gives back-to-back writes of 1 per cycle.
  - The first commit cycle with lock[g]==0 behaves as without the macro.
  - req[g]==0 while locked releases to IDLE with no write.
  - In this mode gnt[g] and ack[g] may be high together.
- Not defined: the lock port is absent; every commit returns to IDLE.

Test Plan:
- Reset: drive reset=1 mid-GRANT between edges -> q=0000, gnt=0000, ack=0000, valid=0 immediately. A later req=0001 is granted to requester 0.
- Single write: req=0001, wdata0=0010 before edge 1 -> gnt=0001 after edge 1. After edge 2: q=0010, ack=0001, owner=0, valid=1, gnt=0000.
- Fairness: req=1111 held, wdata0..3=0001,0010,0100,1000 -> grants in order 0,1,2,3,0, each 2 cycles apart. q sequence is 0001,0010,0100,1000,0001.
- Abandon: req=0010, gnt=0010, then req dropped to 0000 before the next edge -> q unchanged, ack=0000, ptr unchanged. Then req=0110 -> requester 1 granted.
- Wrap-around: after a commit by requester 3, req=1001 -> requester 0 granted, then requester 3 on the following arbitration.
- Lock (PIPO_ARB_LOCK_EN): req0=1 with lock0=1 for 3 commit cycles, wdata0 = 0011, 0101, 0110 -> three consecutive ack=0001, q ends at 0110, and req1=1 stays ungranted. Requester 1 is granted 2 cycles after lock0 falls.
